// File: rtl/regfile_wr_ctrl_if.sv
// Write-port bus for regfile_wr_ctrl: two requester handshakes, clear control,
// and the register-file write port driven by the controller.
interface regfile_wr_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ack;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ack;
  logic              clear_start;
  logic              clear_busy;
  logic              clear_done;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // Requester / client side
  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output clear_start,
    input  req0_ack, req1_ack, clear_busy, clear_done,
    input  wr_en, wr_addr, wr_data
  );

  // Controller side
  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  clear_start,
    output req0_ack, req1_ack, clear_busy, clear_done,
    output wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/regfile_wr_ctrl.sv
// Write-port controller for the 8x8 register file. Two requesters share the
// single write port under round-robin arbitration; a clear sequence can zero
// every register. All outputs are registered and feed the regfile directly.
module regfile_wr_ctrl #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 8
) (
  input  logic             clk,
  input  logic             reset,
  regfile_wr_ctrl_if.slave bus
);

  localparam int NUM_REQ = 2;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t state_q, state_d;

  // Index of the most recently granted requester; 1 at reset so req0 wins the first tie.
  logic last_q, last_d;

  logic              wr_en_q,   wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Requester inputs gathered into packed per-requester arrays
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]             eligible;

  logic              grant;
  logic [ADDR_W-1:0] clr_addr_nx;

  assign req_valid = {bus.req1_valid, bus.req0_valid};
  assign req_addr  = {bus.req1_addr,  bus.req0_addr};
  assign req_data  = {bus.req1_data,  bus.req0_data};

  // A request whose ack is currently visible is still held by its owner; never re-grant it.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_elig
    assign eligible[i] = req_valid[i] & ~ack_q[i];
  end

  // Round-robin pick: a lone eligible requester wins, a tie goes to the one not granted last.
  always_comb begin
    grant = 1'b0;
    if (eligible == 2'b11) grant = ~last_q;
    else                   grant = eligible[1];
  end

  assign clr_addr_nx = wr_addr_q + 1'b1;

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    ack_d     = '0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.clear_start) begin
          // Clear takes priority over any pending request this cycle.
          state_d   = CLEAR;
          wr_en_d   = 1'b1;
          wr_addr_d = '0;
          wr_data_d = '0;
          busy_d    = 1'b1;
          done_d    = (NUM_REGS == 1);
        end else if (|eligible) begin
          wr_en_d      = 1'b1;
          wr_addr_d    = req_addr[grant];
          wr_data_d    = req_data[grant];
          ack_d[grant] = 1'b1;
          last_d       = grant;
        end
      end
      CLEAR: begin
        // The cycle showing the final clear write still belongs to CLEAR, so
        // arbitration only resumes the cycle after clear_done.
        if (done_q) begin
          state_d = IDLE;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = clr_addr_nx;
          wr_data_d = '0;
          busy_d    = 1'b1;
          done_d    = (clr_addr_nx == ADDR_W'(NUM_REGS - 1));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any sequence immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ack_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.req0_ack   = ack_q[0];
  assign bus.req1_ack   = ack_q[1];
  assign bus.clear_busy = busy_q;
  assign bus.clear_done = done_q;

endmodule

// File: tb/tb_regfile_wr_ctrl.sv
// Directed bench for regfile_wr_ctrl: a cycle-by-cycle vector table plus
// hand-written reset-abort and end-to-end regfile sequences.
module tb_regfile_wr_ctrl;

  logic clk = 1'b0;
  logic reset;

  regfile_wr_ctrl_if #(.DATA_W(8), .ADDR_W(3)) bus ();

  regfile_wr_ctrl #(.DATA_W(8), .ADDR_W(3), .NUM_REGS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for regfile_8x8: one write port, asynchronous read.
  logic [7:0] rf [8];
  always @(posedge clk) if (bus.wr_en) rf[bus.wr_addr] <= bus.wr_data;

  typedef struct {
    logic       v0; logic [2:0] a0; logic [7:0] d0;
    logic       v1; logic [2:0] a1; logic [7:0] d1;
    logic       cs;
    logic       e_en; logic [2:0] e_addr; logic [7:0] e_data;
    logic       e_ack0; logic e_ack1; logic e_busy; logic e_done;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int failures = 0;
  int clr_writes = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic v0, input logic [2:0] a0, input logic [7:0] d0,
                     input logic v1, input logic [2:0] a1, input logic [7:0] d1,
                     input logic cs,
                     input logic en, input logic [2:0] ad, input logic [7:0] da,
                     input logic k0, input logic k1, input logic bz, input logic dn);
    vec_t v;
    v = '{v0, a0, d0, v1, a1, d1, cs, en, ad, da, k0, k1, bz, dn};
    vecs.push_back(v);
  endtask

  task automatic drive(input logic v0, input logic [2:0] a0, input logic [7:0] d0,
                       input logic v1, input logic [2:0] a1, input logic [7:0] d1,
                       input logic cs);
    bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
    bus.clear_start = cs;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    step(); step();
    chk("rst wr_en", bus.wr_en, 0);
    chk("rst wr_addr", bus.wr_addr, 0);
    chk("rst wr_data", bus.wr_data, 0);
    chk("rst ack0", bus.req0_ack, 0);
    chk("rst ack1", bus.req1_ack, 0);
    chk("rst busy", bus.clear_busy, 0);
    chk("rst done", bus.clear_done, 0);
    reset = 1'b0;

    //  v0 a0 d0     v1 a1 d1     cs | en ad da     k0 k1 bz dn
    add(1, 3, 8'hA5, 0, 0, 8'h00, 0,   1, 3, 8'hA5, 1, 0, 0, 0); // single req0 write
    add(1, 3, 8'hA5, 0, 0, 8'h00, 0,   0, 3, 8'hA5, 0, 0, 0, 0); // held while acked: no regrant
    add(0, 0, 8'h00, 0, 0, 8'h00, 0,   0, 3, 8'hA5, 0, 0, 0, 0); // quiescent, bus holds
    add(1, 1, 8'h11, 1, 2, 8'h22, 0,   1, 2, 8'h22, 0, 1, 0, 0); // tie, last was 0 -> req1
    add(1, 1, 8'h11, 1, 2, 8'h22, 0,   1, 1, 8'h11, 1, 0, 0, 0);
    add(1, 1, 8'h11, 1, 2, 8'h22, 0,   1, 2, 8'h22, 0, 1, 0, 0);
    add(1, 1, 8'h11, 1, 2, 8'h22, 0,   1, 1, 8'h11, 1, 0, 0, 0);
    add(0, 0, 8'h00, 0, 0, 8'h00, 0,   0, 1, 8'h11, 0, 0, 0, 0);
    add(0, 0, 8'h00, 1, 5, 8'h3C, 1,   1, 0, 8'h00, 0, 0, 1, 0); // clear beats req1
    add(0, 0, 8'h00, 1, 5, 8'h3C, 0,   1, 1, 8'h00, 0, 0, 1, 0);
    add(0, 0, 8'h00, 1, 5, 8'h3C, 0,   1, 2, 8'h00, 0, 0, 1, 0);
    add(0, 0, 8'h00, 1, 5, 8'h3C, 0,   1, 3, 8'h00, 0, 0, 1, 0);
    add(0, 0, 8'h00, 1, 5, 8'h3C, 1,   1, 4, 8'h00, 0, 0, 1, 0); // re-start ignored
    add(0, 0, 8'h00, 1, 5, 8'h3C, 0,   1, 5, 8'h00, 0, 0, 1, 0);
    add(0, 0, 8'h00, 1, 5, 8'h3C, 0,   1, 6, 8'h00, 0, 0, 1, 0);
    add(0, 0, 8'h00, 1, 5, 8'h3C, 0,   1, 7, 8'h00, 0, 0, 1, 1); // final write + done
    add(0, 0, 8'h00, 1, 5, 8'h3C, 0,   0, 7, 8'h00, 0, 0, 0, 0); // still CLEAR, no grant
    add(0, 0, 8'h00, 1, 5, 8'h3C, 0,   1, 5, 8'h3C, 0, 1, 0, 0); // 10th cycle: req1 write
    add(0, 0, 8'h00, 0, 0, 8'h00, 0,   0, 5, 8'h3C, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].v0, vecs[i].a0, vecs[i].d0, vecs[i].v1, vecs[i].a1, vecs[i].d1, vecs[i].cs);
      step();
      if (bus.wr_en && bus.clear_busy) clr_writes++;
      chk($sformatf("row%0d wr_en", i),   bus.wr_en,      vecs[i].e_en);
      chk($sformatf("row%0d wr_addr", i), bus.wr_addr,    vecs[i].e_addr);
      chk($sformatf("row%0d wr_data", i), bus.wr_data,    vecs[i].e_data);
      chk($sformatf("row%0d ack0", i),    bus.req0_ack,   vecs[i].e_ack0);
      chk($sformatf("row%0d ack1", i),    bus.req1_ack,   vecs[i].e_ack1);
      chk($sformatf("row%0d busy", i),    bus.clear_busy, vecs[i].e_busy);
      chk($sformatf("row%0d done", i),    bus.clear_done, vecs[i].e_done);
    end
    chk("clear write count", clr_writes, 8);
    for (int r = 0; r < 8; r++)
      chk($sformatf("rf r%0d after clear", r), rf[r], (r == 5) ? 8'h3C : 8'h00);

    // Reset during clear cycle 3 aborts asynchronously and the clear never resumes.
    drive(0, 0, 0, 0, 0, 0, 1);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    step(); step();
    chk("pre-abort addr", bus.wr_addr, 2);
    #2 reset = 1'b1;
    #1;
    chk("abort wr_en async", bus.wr_en, 0);
    chk("abort busy async", bus.clear_busy, 0);
    step();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("post-abort%0d wr_en", k), bus.wr_en, 0);
      chk($sformatf("post-abort%0d busy", k), bus.clear_busy, 0);
    end
    drive(1, 4, 8'h44, 1, 6, 8'h66, 0);
    step();
    chk("post-reset tie ack0", bus.req0_ack, 1);
    chk("post-reset tie ack1", bus.req1_ack, 0);
    chk("post-reset tie addr", bus.wr_addr, 4);
    chk("post-reset tie data", bus.wr_data, 8'h44);
    drive(0, 0, 0, 0, 0, 0, 0);
    step();

    // End-to-end: req1 writes 0x5A to r6, visible on the read port after the write edge.
    drive(0, 0, 0, 1, 6, 8'h5A, 0);
    step();
    chk("e2e wr_en", bus.wr_en, 1);
    chk("e2e ack1", bus.req1_ack, 1);
    chk("e2e wr_addr", bus.wr_addr, 6);
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    chk("e2e read r6", rf[6], 8'h5A);
    chk("e2e quiescent", bus.wr_en, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
